// File: rtl/if_stage_if.sv
// Fetch-stage bundle: stall/redirect inputs, instruction-memory port and IF/ID outputs.
// master = the fetch stage, slave = its surroundings (hazard logic, imem, decode).
interface if_stage_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        addr_err;

    modport master (
        input  stall, redirect_valid, redirect_target, imem_rdata,
        output imem_addr, imem_en, id_pc, id_inst, id_valid, addr_err
    );

    modport slave (
        output stall, redirect_valid, redirect_target, imem_rdata,
        input  imem_addr, imem_en, id_pc, id_inst, id_valid, addr_err
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, redirect and stall handling.
// Optional macro DELAY_SLOT_EN: keep the word fetched alongside a redirect instead of flushing it.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.master  bus
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] pc_q,      pc_d;
    logic [XLEN-1:0] id_pc_q,   id_pc_d;
    logic [XLEN-1:0] id_inst_q, id_inst_d;
    logic            id_valid_q, id_valid_d;
    logic            addr_err_q, addr_err_d;

    // Next-state: a stall freezes everything and drops any redirect that cycle.
    always_comb begin
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        addr_err_d = 1'b0;
        if (!bus.stall) begin
            id_pc_d = pc_q;
            if (bus.redirect_valid) begin
                pc_d       = {bus.redirect_target[XLEN-1:2], 2'b00};
                addr_err_d = |bus.redirect_target[1:0];
`ifdef DELAY_SLOT_EN
                id_inst_d  = bus.imem_rdata;
                id_valid_d = 1'b1;
`else
                id_inst_d  = NOP_INST;
                id_valid_d = 1'b0;
`endif
            end else begin
                pc_d       = pc_q + XLEN'(4);
                id_inst_d  = bus.imem_rdata;
                id_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            id_pc_q    <= '0;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.imem_en   = ~rst & ~bus.stall;
    assign bus.id_pc     = id_pc_q;
    assign bus.id_inst   = id_inst_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run against a behavioural fetch model.
module tb_if_stage;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;
`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   checks = 0;
    int   errors = 0;

    if_stage_if bus ();
    if_stage_if bus2 ();

    if_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
        .clk (clk), .rst (rst),  .bus (bus.master)
    );
    if_stage #(.RESET_PC(RPC2), .NOP_INST(NOP)) dut2 (
        .clk (clk), .rst (rst2), .bus (bus2.master)
    );

    always #5 clk = ~clk;

    // ROM: word[i] = i
    function automatic logic [31:0] rom(input logic [31:0] a);
        return a >> 2;
    endfunction

    assign bus.imem_rdata  = rom(bus.imem_addr);
    assign bus2.imem_rdata = rom(bus2.imem_addr);

    logic en_seen;

    // Apply inputs, sample the combinational enable, then cross one edge.
    task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] t);
        rst = r;
        bus.stall = s;
        bus.redirect_valid = rv;
        bus.redirect_target = t;
        #1;
        en_seen = bus.imem_en;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0);
        drive(1, 1, 1, 32'h0000_0123);
        chk("reset_pc", bus.imem_addr, 32'h0);
        chk("reset_id_pc", bus.id_pc, 32'h0);
        chk("reset_id_inst", bus.id_inst, NOP);
        chk("reset_id_valid", 32'(bus.id_valid), 32'h0);
        chk("reset_addr_err", 32'(bus.addr_err), 32'h0);
        chk("reset_imem_en", 32'(en_seen), 32'h0);
    endtask

    task automatic test_free_run();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0);
            chk("run_en", 32'(en_seen), 32'h1);
            chk("run_id_pc", bus.id_pc, 32'(4 * k));
            chk("run_id_inst", bus.id_inst, 32'(k));
            chk("run_id_valid", 32'(bus.id_valid), 32'h1);
        end
        chk("run_pc", bus.imem_addr, 32'h10);
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 0);
            chk("stall_en", 32'(en_seen), 32'h0);
            chk("stall_pc", bus.imem_addr, 32'h10);
            chk("stall_id_pc", bus.id_pc, 32'h0C);
            chk("stall_id_inst", bus.id_inst, 32'h3);
        end
        drive(0, 0, 0, 0);
        chk("resume_id_pc", bus.id_pc, 32'h10);
        chk("resume_id_inst", bus.id_inst, 32'h4);
        chk("resume_pc", bus.imem_addr, 32'h14);
    endtask

    task automatic test_back_to_back();
        drive(0, 0, 1, 32'h20);
        chk("b2b_first_pc", bus.imem_addr, 32'h20);
        drive(0, 0, 1, 32'h100);
        chk("redir_pc", bus.imem_addr, 32'h100);
        chk("redir_id_pc", bus.id_pc, 32'h20);
        chk("redir_id_valid", 32'(bus.id_valid), 32'(DS));
        chk("redir_id_inst", bus.id_inst, DS ? 32'h8 : NOP);
        chk("redir_addr_err", 32'(bus.addr_err), 32'h0);
        drive(0, 0, 0, 0);
        chk("post_redir_id_pc", bus.id_pc, 32'h100);
        chk("post_redir_id_inst", bus.id_inst, 32'h40);
        chk("post_redir_valid", 32'(bus.id_valid), 32'h1);
    endtask

    task automatic test_stall_redirect();
        drive(0, 0, 1, 32'h40);
        drive(0, 1, 1, 32'h83);
        chk("stallredir_pc", bus.imem_addr, 32'h40);
        chk("stallredir_err", 32'(bus.addr_err), 32'h0);
        drive(0, 0, 1, 32'h80);
        chk("stallredir_retry_pc", bus.imem_addr, 32'h80);
    endtask

    task automatic test_misaligned();
        drive(0, 0, 1, 32'h203);
        chk("misal_pc", bus.imem_addr, 32'h200);
        chk("misal_err", 32'(bus.addr_err), 32'h1);
        drive(0, 0, 0, 0);
        chk("misal_err_clear", 32'(bus.addr_err), 32'h0);
        chk("misal_next_pc", bus.imem_addr, 32'h204);
    endtask

    task automatic test_wrap();
        rst2 = 1'b1;
        @(posedge clk); #1;
        chk("wrap_reset_pc", bus2.imem_addr, RPC2);
        rst2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("wrap_id_pc", bus2.id_pc, RPC2 + 32'(4 * k));
            chk("wrap_err", 32'(bus2.addr_err), 32'h0);
        end
        chk("wrap_pc", bus2.imem_addr, 32'h4);
        bus2.redirect_valid = 1'b1;
        bus2.redirect_target = 32'h0000_0301;
        rst2 = 1'b1;
        @(posedge clk); #1;
        chk("wrap_rst_redir_pc", bus2.imem_addr, RPC2);
        chk("wrap_rst_redir_valid", 32'(bus2.id_valid), 32'h0);
        chk("wrap_rst_redir_err", 32'(bus2.addr_err), 32'h0);
        bus2.redirect_valid = 1'b0;
    endtask

    // Behavioural model: what IF/ID should hold after each edge.
    logic [31:0] m_pc, m_id_pc, m_id_inst;
    logic        m_id_valid, m_err;

    task automatic test_random();
        logic r, s, rv;
        logic [31:0] t;
        for (int n = 0; n < 400; n++) begin
            r  = (n == 0) || ($urandom_range(0, 31) == 0);
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 2))
                0:       t = $urandom;
                1:       t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: t = 32'($urandom_range(0, 255));
            endcase
            drive(r, s, rv, t);
            if (r) begin
                m_pc = 32'h0; m_id_pc = 32'h0; m_id_inst = NOP;
                m_id_valid = 1'b0; m_err = 1'b0;
            end else if (s) begin
                m_err = 1'b0;
            end else begin
                m_id_pc    = m_pc;
                m_id_valid = !(rv && !DS);
                m_id_inst  = m_id_valid ? rom(m_pc) : NOP;
                m_err      = rv && (t % 4 != 0);
                m_pc       = rv ? t - (t % 4) : m_pc + 32'd4;
            end
            chk("rand_en", 32'(en_seen), 32'(!r && !s));
            chk("rand_pc", bus.imem_addr, m_pc);
            chk("rand_id_pc", bus.id_pc, m_id_pc);
            chk("rand_id_inst", bus.id_inst, m_id_inst);
            chk("rand_id_valid", 32'(bus.id_valid), 32'(m_id_valid));
            chk("rand_addr_err", 32'(bus.addr_err), 32'(m_err));
        end
    endtask

    initial begin
        rst = 1'b1;
        rst2 = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = '0;
        bus2.stall = 1'b0;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_target = '0;
        @(posedge clk); #1;
        test_reset();
        test_free_run();
        test_stall();
        test_back_to_back();
        test_stall_redirect();
        test_misaligned();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0000: instruction word placed in IF/ID on flush or reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hazard hold request from the decode/hazard logic.
REQ-006 SHALL have port redirect_valid  input  1  taken branch/jump resolved in ID.
REQ-007 SHALL have port redirect_target  input  32  new fetch address.
REQ-008 SHALL have port imem_rdata  input  32  instruction word, combinational read of imem_addr.
REQ-009 SHALL have port imem_addr  output  32  current PC, driven directly from the PC register.
REQ-010 SHALL have port imem_en  output  1  fetch enable to instruction memory.
REQ-011 SHALL have port id_pc  output  32  IF/ID registered PC.
REQ-012 SHALL have port id_inst  output  32  IF/ID registered instruction.
REQ-013 SHALL have port id_valid  output  1  IF/ID holds a real instruction.
REQ-014 SHALL have port addr_err  output  1  one-cycle registered pulse: misaligned redirect_target.

Function
REQ-015 SHALL hold a 32-bit PC register; imem_addr = PC at all times.
REQ-016 SHALL drive imem_en = ~rst & ~stall.
REQ-017 Normal cycle (stall=0, redirect_valid=0): id_pc<=PC, id_inst<=imem_rdata, id_valid<=1, PC<=PC+4.
REQ-018 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no error flagged.
REQ-019 stall=1: PC, id_pc, id_inst, id_valid SHALL all hold; redirect_valid SHALL be ignored that cycle (the stalled ID stage re-presents it).
REQ-020 redirect (stall=0, redirect_valid=1): PC<={redirect_target[31:2],2'b00}; IF/ID update per REQ-027/REQ-028.
REQ-021 addr_err SHALL be 1 for exactly the cycle after an accepted redirect with redirect_target[1:0]!=0, else 0.
REQ-022 Fetch latency: instruction at address A SHALL appear on id_inst one clock after PC==A with stall=0.
REQ-023 Back-to-back redirects on consecutive unstalled cycles SHALL each be accepted; the last one determines PC.

Reset
REQ-024 While rst=1 at a rising edge: PC<=RESET_PC, id_pc<=0, id_inst<=NOP_INST, id_valid<=0, addr_err<=0.
REQ-025 rst SHALL dominate stall and redirect_valid; reset mid-stall or mid-redirect discards both.
REQ-026 First edge with rst=0 SHALL perform a normal fetch of RESET_PC (id_pc=RESET_PC one cycle later).

Configuration
REQ-027 With DELAY_SLOT_EN defined: on accepted redirect, the word at the current PC (delay slot) SHALL be latched into IF/ID as in REQ-017 (id_valid<=1).
REQ-028 Without DELAY_SLOT_EN: on accepted redirect, IF/ID SHALL be flushed: id_inst<=NOP_INST, id_valid<=0, id_pc<=PC.

Verification
REQ-029 Reset then free-run, ROM word[i]=i: id_pc 0,4,8,12 and id_inst 0,1,2,3 on cycles 1-4 after reset release; id_valid=1 from cycle 1.
REQ-030 stall=1 for 3 cycles with PC=0x10: imem_en=0, PC and IF/ID frozen at 0x10/(id_pc=0x0C); resume fetches 0x10 next.
REQ-031 redirect to 0x100 while PC=0x20: next cycle PC=0x100; without DELAY_SLOT_EN id_valid=0, id_inst=NOP_INST; with it id_pc=0x20, id_valid=1.
REQ-032 redirect_valid=1 and stall=1 same cycle at PC=0x40: PC stays 0x40; redirect repeated with stall=0 next cycle -> PC=target.
REQ-033 redirect_target=0x203: PC=0x200, addr_err=1 for one cycle only.
REQ-034 RESET_PC=0xFFFF_FFF8, run 3 cycles: id_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; rst asserted mid-redirect -> PC=RESET_PC, id_valid=0.
